mem_map_ctrl: RTL and testbench

//  Paged memory-map controller for the 6809 system. Takes over from the top level the cpuClock

---
 rtl/mem_map_pkg.sv | 18 +
 rtl/mem_map_cycle_fsm.sv | 67 ++++++
 rtl/mem_map_ctrl.sv | 121 ++++++++++++
 tb/tb_mem_map_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// Shared types and field layout for the paged memory-map controller.
package mem_map_pkg;

  typedef enum logic [1:0] {REG_RAM, REG_ROM, REG_IO, REG_CFG} region_e;
  typedef enum logic [1:0] {ST_HI, ST_LO, ST_WAIT} cycle_state_e;

  localparam int         CTRL_ROM_INH = 0;
  localparam int         CTRL_MAP_EN  = 7;
  localparam logic [7:0] CTRL_MASK    = 8'h81;
  localparam int         PAGE_WP_BIT  = 7;
  localparam int         WAIT_W       = 4;

  // Physical page field width; must stay below the WP bit so both fit one byte.
  function automatic int phys_width(input int ext_aw, input int page_bits);
    return ext_aw - page_bits;
  endfunction

endpackage

// File: rtl/mem_map_cycle_fsm.sv
// CPU clock generator: one-cycle high phase, low phase stretched by the latched wait count.
module mem_map_cycle_fsm
  import mem_map_pkg::*;
(
  input  logic              cpuClockx2,
  input  logic              n_reset,
  input  logic [WAIT_W-1:0] waitSel,
  input  logic              cpuRw,
  input  logic              blockWr,
  output logic              cpuClk,
  output logic              nMemRd,
  output logic              nMemWr,
  output logic              commit,
  output logic              wpFault,
  output cycle_state_e      state
);

  logic [WAIT_W-1:0] waitLat;
  logic [WAIT_W-1:0] cnt;
  logic              lowPhase;

  always_ff @(posedge cpuClockx2) begin
    if (!n_reset) begin
      state   <= ST_HI;
      cpuClk  <= 1'b1;
      waitLat <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        ST_HI: begin
          state   <= ST_LO;
          cpuClk  <= 1'b0;
          waitLat <= waitSel;
        end
        ST_LO: begin
          if (waitLat == '0) begin
            state  <= ST_HI;
            cpuClk <= 1'b1;
          end else begin
            state <= ST_WAIT;
            cnt   <= waitLat - 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state  <= ST_HI;
            cpuClk <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state  <= ST_HI;
          cpuClk <= 1'b1;
        end
      endcase
    end
  end

  // Strobes depend only on registered state plus the CPU's stable rw/address.
  assign lowPhase = (state == ST_LO) || (state == ST_WAIT);
  assign commit   = ((state == ST_LO) && (waitLat == '0)) || ((state == ST_WAIT) && (cnt == '0));
  assign nMemRd   = !(lowPhase && cpuRw);
  assign nMemWr   = !(lowPhase && !cpuRw && !blockWr);
  assign wpFault  = commit && blockWr;

endmodule

// File: rtl/mem_map_ctrl.sv
// Paged memory-map controller: region decode, page register file, address translation.
module mem_map_ctrl
  import mem_map_pkg::*;
#(
  parameter int          PAGE_BITS = 13,
  parameter int          EXT_AW    = 19,
  parameter logic [15:0] CFG_BASE  = 16'hFFE0,
  parameter logic [15:0] IO_BASE   = 16'hFFD0,
  parameter int          ROM_WAIT  = 0,
  parameter int          RAM_WAIT  = 0,
  parameter int          IO_WAIT   = 1
) (
  input  logic              cpuClockx2,
  input  logic              n_reset,
  input  logic [15:0]       cpu_addr,
  input  logic              cpu_rw,
  input  logic [7:0]        cpu_dout,
  output logic              cpu_clk,
  output logic              n_mem_rd,
  output logic              n_mem_wr,
  output logic [EXT_AW-1:0] ext_addr,
  output logic              n_ram_cs,
  output logic              n_rom_cs,
  output logic              n_io_cs,
  output logic              cfg_sel,
  output logic [7:0]        cfg_rdata,
  output logic              rom_inhibit,
  output logic              wp_fault,
  output cycle_state_e      dbg_state
);

  localparam int NPAGE  = 2 ** (16 - PAGE_BITS);
  localparam int IDX_W  = 16 - PAGE_BITS;
  localparam int PHYS_W = phys_width(EXT_AW, PAGE_BITS);

  logic [PHYS_W-1:0] pagePhys [NPAGE];
  logic [NPAGE-1:0]  pageWp;
  logic [7:0]        ctrlReg;
  region_e           region;
  logic [15:0]       cfgOff;
  logic              cfgHit, ioHit, isCtrl, mapEn, blockWr, commit;
  logic [IDX_W-1:0]  curPage, cfgPage;
  logic [WAIT_W-1:0] waitSel;

  assign mapEn       = ctrlReg[CTRL_MAP_EN];
  assign rom_inhibit = ctrlReg[CTRL_ROM_INH];
  assign cfgOff      = cpu_addr - CFG_BASE;
  assign cfgHit      = (cpu_addr >= CFG_BASE) && (cpu_addr <= CFG_BASE + 16'(NPAGE));
  assign ioHit       = (cpu_addr[15:4] == IO_BASE[15:4]);
  assign isCtrl      = (cfgOff == 16'(NPAGE));
  assign cfgPage     = cfgOff[IDX_W-1:0];
  assign curPage     = cpu_addr[15:PAGE_BITS];

  always_comb begin
    region = REG_RAM;
    if (cfgHit)                                         region = REG_CFG;
    else if (ioHit)                                     region = REG_IO;
    else if (cpu_addr[15] && cpu_addr[13] && !rom_inhibit) region = REG_ROM;
  end

  assign cfg_sel  = (region == REG_CFG);
  assign n_io_cs  = (region != REG_IO);
  assign n_rom_cs = (region != REG_ROM);
  assign n_ram_cs = (region != REG_RAM);

  always_comb begin
    waitSel = '0;
    case (region)
      REG_ROM: waitSel = WAIT_W'(ROM_WAIT);
      REG_RAM: waitSel = WAIT_W'(RAM_WAIT);
      REG_IO:  waitSel = WAIT_W'(IO_WAIT);
      default: waitSel = '0;
    endcase
  end

  assign ext_addr = mapEn ? {pagePhys[curPage], cpu_addr[PAGE_BITS-1:0]} : EXT_AW'(cpu_addr);
  assign blockWr  = (region == REG_RAM) && mapEn && pageWp[curPage] && !cpu_rw;

  always_comb begin
    cfg_rdata = '0;
    if (cfgHit) begin
      if (isCtrl) begin
        cfg_rdata = ctrlReg;
      end else begin
        cfg_rdata[PHYS_W-1:0]  = pagePhys[cfgPage];
        cfg_rdata[PAGE_WP_BIT] = pageWp[cfgPage];
      end
    end
  end

  // Config writes land on the last low-phase cycle so the access in flight keeps its mapping.
  always_ff @(posedge cpuClockx2) begin
    if (!n_reset) begin
      ctrlReg <= '0;
      pageWp  <= '0;
      for (int i = 0; i < NPAGE; i++) pagePhys[i] <= PHYS_W'(i);
    end else if (commit && cfg_sel && !cpu_rw) begin
      if (isCtrl) begin
        ctrlReg <= cpu_dout & CTRL_MASK;
      end else begin
        pagePhys[cfgPage] <= cpu_dout[PHYS_W-1:0];
        pageWp[cfgPage]   <= cpu_dout[PAGE_WP_BIT];
      end
    end
  end

  mem_map_cycle_fsm u_cycle (
    .cpuClockx2 (cpuClockx2),
    .n_reset    (n_reset),
    .waitSel    (waitSel),
    .cpuRw      (cpu_rw),
    .blockWr    (blockWr),
    .cpuClk     (cpu_clk),
    .nMemRd     (n_mem_rd),
    .nMemWr     (n_mem_wr),
    .commit     (commit),
    .wpFault    (wp_fault),
    .state      (dbg_state)
  );

endmodule

// File: tb/tb_mem_map_ctrl.sv
// Directed bench for mem_map_ctrl: decode, paging, write protect, wait states, reset.
module tb_mem_map_ctrl;
  import mem_map_pkg::*;

  logic         cpuClockx2 = 1'b0;
  logic         n_reset;
  logic [15:0]  cpu_addr;
  logic         cpu_rw;
  logic [7:0]   cpu_dout;
  logic         cpu_clk, n_mem_rd, n_mem_wr, n_ram_cs, n_rom_cs, n_io_cs;
  logic         cfg_sel, rom_inhibit, wp_fault;
  logic [18:0]  ext_addr;
  logic [7:0]   cfg_rdata;
  cycle_state_e dbg_state;

  int checks = 0;
  int errors = 0;

  // Observations gathered over the low phase of the last access.
  int low_cnt, fault_cnt;
  logic wr_seen, rd_seen, io_all;

  mem_map_ctrl dut (
    .cpuClockx2 (cpuClockx2),
    .n_reset    (n_reset),
    .cpu_addr   (cpu_addr),
    .cpu_rw     (cpu_rw),
    .cpu_dout   (cpu_dout),
    .cpu_clk    (cpu_clk),
    .n_mem_rd   (n_mem_rd),
    .n_mem_wr   (n_mem_wr),
    .ext_addr   (ext_addr),
    .n_ram_cs   (n_ram_cs),
    .n_rom_cs   (n_rom_cs),
    .n_io_cs    (n_io_cs),
    .cfg_sel    (cfg_sel),
    .cfg_rdata  (cfg_rdata),
    .rom_inhibit(rom_inhibit),
    .wp_fault   (wp_fault),
    .dbg_state  (dbg_state)
  );

  always #5 cpuClockx2 = ~cpuClockx2;

  task automatic step();
    @(posedge cpuClockx2);
    #1;
  endtask

  task automatic wait_hi();
    for (int i = 0; i < 4 && cpu_clk !== 1'b1; i++) step();
    checks++;
    if (cpu_clk !== 1'b1) begin
      errors++;
      $display("FAIL wait_hi got %b exp 1", cpu_clk);
    end
  endtask

  task automatic access(input logic [15:0] addr, input logic rw, input logic [7:0] data);
    wait_hi();
    cpu_addr = addr; cpu_rw = rw; cpu_dout = data;
    low_cnt = 0; fault_cnt = 0; wr_seen = 1'b0; rd_seen = 1'b0; io_all = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (cpu_clk !== 1'b0) break;
      low_cnt++;
      if (n_mem_wr === 1'b0) wr_seen = 1'b1;
      if (n_mem_rd === 1'b0) rd_seen = 1'b1;
      if (wp_fault === 1'b1) fault_cnt++;
      if (n_io_cs !== 1'b0) io_all = 1'b0;
    end
    cpu_rw = 1'b1;
  endtask

  task automatic test_reset();
    n_reset = 1'b0; cpu_addr = 16'hFFE1; cpu_rw = 1'b1; cpu_dout = 8'h00;
    step(); step();
    checks++;
    if ({cpu_clk, n_mem_rd, n_mem_wr, wp_fault, rom_inhibit} !== 5'b11100) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 11100", {cpu_clk, n_mem_rd, n_mem_wr, wp_fault, rom_inhibit});
    end
    checks++;
    if (cfg_rdata !== 8'h01) begin
      errors++;
      $display("FAIL reset_page1 got %h exp 01", cfg_rdata);
    end
    cpu_addr = 16'h1234;
    n_reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (cpu_clk !== logic'(i % 2)) begin
        errors++;
        $display("FAIL idle_toggle%0d got %b exp %b", i, cpu_clk, logic'(i % 2));
      end
    end
  endtask

  task automatic test_decode_default();
    cpu_addr = 16'h1234; #1;
    checks++;
    if (ext_addr !== 19'h01234 || n_ram_cs !== 1'b0) begin
      errors++;
      $display("FAIL flat_addr got %h/%b exp 01234/0", ext_addr, n_ram_cs);
    end
    cpu_addr = 16'hE000; #1;
    checks++;
    if ({n_rom_cs, n_ram_cs, n_io_cs, cfg_sel} !== 4'b0110) begin
      errors++;
      $display("FAIL rom_e000 got %b exp 0110", {n_rom_cs, n_ram_cs, n_io_cs, cfg_sel});
    end
    cpu_addr = 16'h8000; #1;
    checks++;
    if (n_ram_cs !== 1'b0) begin
      errors++;
      $display("FAIL ram_8000 got %b exp 0", n_ram_cs);
    end
  endtask

  task automatic test_control();
    access(16'hFFE8, 1'b0, 8'h81);
    checks++;
    if (rom_inhibit !== 1'b1) begin
      errors++;
      $display("FAIL ctrl_rom_inh got %b exp 1", rom_inhibit);
    end
    cpu_addr = 16'hFFE8; #1;
    checks++;
    if (cfg_rdata !== 8'h81 || cfg_sel !== 1'b1) begin
      errors++;
      $display("FAIL ctrl_read got %h/%b exp 81/1", cfg_rdata, cfg_sel);
    end
    cpu_addr = 16'hE000; #1;
    checks++;
    if (n_ram_cs !== 1'b0 || n_rom_cs !== 1'b1 || ext_addr !== 19'h0E000) begin
      errors++;
      $display("FAIL e000_ram got %b%b/%h exp 01/0e000", n_ram_cs, n_rom_cs, ext_addr);
    end
    cpu_addr = 16'hFFE9; #1;
    checks++;
    if (cfg_sel !== 1'b0 || n_ram_cs !== 1'b0) begin
      errors++;
      $display("FAIL ffe9_edge got %b%b exp 00", cfg_sel, n_ram_cs);
    end
  endtask

  task automatic test_paging();
    access(16'hFFE1, 1'b0, 8'h3F);
    access(16'h2345, 1'b1, 8'h00);
    checks++;
    if (low_cnt !== 1 || rd_seen !== 1'b1) begin
      errors++;
      $display("FAIL ram_read got %0d/%b exp 1/1", low_cnt, rd_seen);
    end
    checks++;
    if (ext_addr !== 19'h7E345) begin
      errors++;
      $display("FAIL page3f_addr got %h exp 7e345", ext_addr);
    end
    cpu_addr = 16'hFFE1; #1;
    checks++;
    if (cfg_rdata !== 8'h3F) begin
      errors++;
      $display("FAIL page1_read got %h exp 3f", cfg_rdata);
    end
  endtask

  task automatic test_write_protect();
    access(16'hFFE2, 1'b0, 8'h85);
    cpu_addr = 16'hFFE2; #1;
    checks++;
    if (cfg_rdata !== 8'h85) begin
      errors++;
      $display("FAIL page2_read got %h exp 85", cfg_rdata);
    end
    access(16'h4000, 1'b0, 8'h55);
    checks++;
    if (wr_seen !== 1'b0 || fault_cnt !== 1) begin
      errors++;
      $display("FAIL wp_block got wr=%b faults=%0d exp wr=0 faults=1", wr_seen, fault_cnt);
    end
    cpu_addr = 16'h4000; #1;
    checks++;
    if (ext_addr !== 19'h0A000 || wp_fault !== 1'b0) begin
      errors++;
      $display("FAIL wp_addr got %h/%b exp 0a000/0", ext_addr, wp_fault);
    end
    access(16'h6000, 1'b0, 8'hAA);
    checks++;
    if (wr_seen !== 1'b1 || fault_cnt !== 0) begin
      errors++;
      $display("FAIL unprot_wr got wr=%b faults=%0d exp wr=1 faults=0", wr_seen, fault_cnt);
    end
  endtask

  task automatic test_io_wait();
    access(16'hFFD0, 1'b1, 8'h00);
    checks++;
    if (low_cnt !== 2 || io_all !== 1'b1) begin
      errors++;
      $display("FAIL io_wait got low=%0d io=%b exp low=2 io=1", low_cnt, io_all);
    end
    access(16'hFFDF, 1'b0, 8'h00);
    checks++;
    if (low_cnt !== 2 || io_all !== 1'b1 || wr_seen !== 1'b1) begin
      errors++;
      $display("FAIL io_top got low=%0d io=%b wr=%b exp 2/1/1", low_cnt, io_all, wr_seen);
    end
  endtask

  task automatic test_reset_in_wait();
    wait_hi();
    cpu_addr = 16'hFFD0; cpu_rw = 1'b1;
    step(); step();
    checks++;
    if (dbg_state !== ST_WAIT) begin
      errors++;
      $display("FAIL reach_wait got %0d exp %0d", dbg_state, ST_WAIT);
    end
    n_reset = 1'b0;
    step();
    checks++;
    if ({cpu_clk, n_mem_rd, n_mem_wr} !== 3'b111) begin
      errors++;
      $display("FAIL reset_wait got %b exp 111", {cpu_clk, n_mem_rd, n_mem_wr});
    end
    cpu_addr = 16'hFFE1; #1;
    checks++;
    if (cfg_rdata !== 8'h01 || rom_inhibit !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs got %h/%b exp 01/0", cfg_rdata, rom_inhibit);
    end
    n_reset = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_decode_default();
    test_control();
    test_paging();
    test_write_protect();
    test_io_wait();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
